par8_bus_if: RTL

//  Clock-domain front end for the RPi 8-bit parallel bus. Sits between the board

---
 rtl/par8_bus_if.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/par8_bus_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : par8_bus_if
//  Purpose  : Clock-domain front end for the RPi 8-bit parallel bus.
//             Oversamples bus_clk/bus_rnw/bus_data_in in clk. RPi write
//             cycles become a valid/ready byte stream through an RX FIFO.
//             RPi read cycles are served from a one-byte TX holding register.
//             The pin tristate lives at the board top; only data/oe leave here.
//  Ports    : clk, reset_n (async assert, active-low)
//             bus_clk, bus_rnw, bus_data_in    - raw pins, async to clk
//             bus_data_out, bus_data_oe        - read data and drive enable
//             rx_data/rx_valid/rx_ready        - received byte stream
//             tx_data/tx_valid/tx_ready        - byte offered to the RPi
//             rx_overflow, tx_underrun         - sticky errors, err_clr clears
//             rx_count                         - accepted bytes, wrapping
//  Revision : 1.0  initial release
// ============================================================================
module par8_bus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bus_clk,
  input  logic             bus_rnw,
  input  logic [7:0]       bus_data_in,
  output logic [7:0]       bus_data_out,
  output logic             bus_data_oe,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             rx_overflow,
  output logic             tx_underrun,
  input  logic             err_clr,
  output logic [CNT_W-1:0] rx_count
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_WRITE = 2'd0,
    S_TURN  = 2'd1,
    S_READ  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizers: strobe, direction and data all see the same depth
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync_clk;
  logic [SYNC_STAGES-1:0] r_sync_rnw;
  logic [SYNC_STAGES-1:0] r_fill;
  logic [7:0]             r_sync_data [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_clk <= '0;
      r_sync_rnw <= '0;
      r_fill     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync_data[i] <= 8'h00;
    end else begin
      r_sync_clk     <= {r_sync_clk[SYNC_STAGES-2:0], bus_clk};
      r_sync_rnw     <= {r_sync_rnw[SYNC_STAGES-2:0], bus_rnw};
      r_fill         <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sync_data[0] <= bus_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync_data[i] <= r_sync_data[i-1];
    end
  end

  logic w_s_clk;
  logic w_s_rnw;
  logic w_filled;
  assign w_s_clk  = r_sync_clk[SYNC_STAGES-1];
  assign w_s_rnw  = r_sync_rnw[SYNC_STAGES-1];
  assign w_filled = r_fill[SYNC_STAGES-1];

  // Edge detector. Both taps reset high and are held high until the
  // synchronizer has flushed its reset zeros, so a strobe that is already
  // high when reset releases never looks like a rising edge.
  logic       r_clk_d;
  logic       r_clk_prev;
  logic [7:0] r_data_d;
  logic       w_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_d    <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_d   <= 8'h00;
    end else begin
      r_clk_d    <= w_filled ? w_s_clk : 1'b1;
      r_clk_prev <= r_clk_d;
      r_data_d   <= r_sync_data[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_clk_d & ~r_clk_prev;

  // --------------------------------------------------------------------------
  // Direction FSM
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_oe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_WRITE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_oe        = 1'b0;
    case (r_state)
      S_WRITE: if (w_s_rnw) w_state_nxt = S_TURN;
      S_TURN:  w_state_nxt = w_s_rnw ? S_READ : S_WRITE;
      S_READ: begin
        w_oe = 1'b1;
        if (!w_s_rnw) w_state_nxt = S_WRITE;
      end
      default: w_state_nxt = S_WRITE;
    endcase
  end

  assign bus_data_oe = w_oe;

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] w_level;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_push_ok;
  logic        w_ovf_set;

  assign w_level   = r_wptr - r_rptr;
  assign w_full    = (w_level == C_DEPTH);
  assign rx_valid  = (w_level != '0);
  assign rx_data   = r_mem[r_rptr[AW-1:0]];
  assign w_push    = w_rise & (r_state == S_WRITE);
  assign w_pop     = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot for a push that finds us full.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & ~w_push_ok;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= r_data_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      rx_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr   <= r_wptr + 1'b1;
        rx_count <= rx_count + CNT_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // TX holding register
  // --------------------------------------------------------------------------
  logic       r_tx_full;
  logic [7:0] r_tx_byte;
  logic       w_tx_consume;
  logic       w_tx_load;
  logic       w_unr_set;

  assign w_tx_consume = w_rise & (r_state == S_READ) & r_tx_full;
  assign w_unr_set    = w_rise & (r_state == S_READ) & ~r_tx_full;
  // A byte being consumed this cycle may be replaced in the same cycle.
  assign tx_ready     = ~r_tx_full | w_tx_consume;
  assign w_tx_load    = tx_valid & tx_ready;
  assign bus_data_out = r_tx_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_full <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      if (w_tx_load) begin
        r_tx_full <= 1'b1;
        r_tx_byte <= tx_data;
      end else if (w_tx_consume) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a new error wins over a coincident clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_overflow <= (rx_overflow & ~err_clr) | w_ovf_set;
      tx_underrun <= (tx_underrun & ~err_clr) | w_unr_set;
    end
  end

endmodule
`default_nettype wire
